fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction cache.
- Accepts the cache's 8-byte fetch response: two 32-bit instructions plus per-instruction predecode tags.
- Splits the response into per-instruction entries tagged with PC and queues them in a circular FIFO.
- Presents up to two in-order instructions per cycle to decode.
- Decouples cache hit/miss latency from decode stalls and discards contents on a pipeline redirect.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), index width; the internal count is PTR_W+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  redirect; discard all queued entries.
- in_valid  in  1  cache response valid (cache data_ok).
- in_pc  in  32  fetch address of the request; bit 2 selects the start slot.
- in_data  in  64  [31:0] instruction at {in_pc[31:3],3'b000}; [63:32] instruction at +4.
- in_predecode  in  4  2-bit predecode_t per slot: [1:0] slot0, [3:2] slot1.
- in_ready  out  1  queue can accept a full response this cycle.
- out_valid  out  2  [0] head entry valid; [1] head+1 entry valid.
- out_pc  out  64  [31:0] head PC; [63:32] head+1 PC.
- out_instr  out  64  head and head+1 instructions, same packing.
- out_predecode  out  4  head and head+1 predecode, same packing.
- out_accept  in  2  decode consumes entries: 2'b00 none, 2'b01 one, 2'b11 two.
- count  out  PTR_W+1  current occupancy, for debug and performance counters.

Behaviour:
- Reset (resetn low, asynchronous): head=0, tail=0, count=0. Outputs: out_valid=2'b00, in_ready=1, count=0. Storage contents are don't-care and are not reset.
- in_ready = (DEPTH - count) >= 2, from registered count only.
  - Same-cycle pops are not credited, so there is no combinational path out_accept -> in_ready.
- Push occurs when in_valid & in_ready:
  - in_pc[2]==0: write two entries. tail gets {pc=in_pc&~7, instr=in_data[31:0], pd=in_predecode[1:0]}; tail+1 gets {pc+4, in_data[63:32], in_predecode[3:2]}; tail += 2.
  - in_pc[2]==1: write one entry at tail: {in_pc, in_data[63:32], in_predecode[3:2]}; tail += 1.
- in_valid & ~in_ready: the response is dropped. Upstream must not assert data_ok while in_ready=0. The bench flags this as an error; the RTL ignores it.
- Outputs are combinational reads of storage[head] and storage[head+1], indices modulo DEPTH.
  - out_valid[0] = count>=1; out_valid[1] = count>=2.
  - Data fields of an invalid slot are don't-care.
- Pop count:
  - out_accept=01 with out_valid[0] -> 1.
  - out_accept=11 with out_valid[1] -> 2.
  - out_accept=11 with only out_valid[0] -> 1.
  - 2'b10 is illegal and treated as 0.
  - head += pop count.
- Same cycle push and pop: count_next = count + push_n - pop_n. Both apply in one edge. Never overflows, since push is gated by registered free space.
- Latency: an entry pushed at edge N appears on out_* after edge N; there is no bypass.
- Wrap-around: pointers increment modulo DEPTH. A two-entry push straddling index DEPTH-1 -> 0 writes both slots correctly. The head+1 read wraps likewise.
- flush (synchronous, highest priority): next edge sets head=tail=count=0. A push and pop in the same cycle are both ignored. out_valid=00 and in_ready=1 in the following cycle.
- Reset asserted mid-operation clears state immediately. The first push is accepted on the first edge after resetn rises.
- The queue holds no FSM beyond the pointers and count; count is the single source of full/empty.

Decomposition:
- Shared package:
  - predecode_t enum (normal, is_branch, is_ret, is_call; 2 bits), reused from the cache.
  - fq_entry_t struct {addr_t pc; word_t instr; predecode_t pd}.
  - FQ_DEPTH default constant.
- Storage is a plain register array of fq_entry_t with two write ports and two read ports, written inline in this module. No sub-module.

Test Plan:
- Reset then push in_pc=0xBFC00000, data={0x24020002,0x24010001}, no accept -> next cycle out_valid=11, out_pc={0xBFC00004,0xBFC00000}, count=2.
- Push in_pc=0xBFC00014 (bit2=1), data[63:32]=0x10000003, pd slot1=is_branch -> single entry pc=0xBFC00014, out_predecode[1:0]=is_branch, count=1.
- DEPTH=8, hold out_accept=00, push 4 aligned pairs -> count=8, in_ready=0. Then accept=11 -> count=6, in_ready=1 the next cycle.
- Drive head/tail to 7, push aligned pair 0x80000000 -> entries land at indices 7 and 0; out_pc reads {0x80000004,0x80000000}.
- count=4, simultaneous push of a pair with accept=11 -> count stays 4 and the order is preserved across 10 cycles of steady state.
- count=5 with push and accept in the same cycle as flush=1 -> next cycle count=0, out_valid=00, in_ready=1. Asserting resetn=0 mid-stream clears count to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: predecode tags, address/word types and the queue entry.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 8;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  // Predecode tag produced alongside each instruction by the instruction cache
  typedef enum logic [1:0] {
    PD_NORMAL    = 2'd0,
    PD_IS_BRANCH = 2'd1,
    PD_IS_RET    = 2'd2,
    PD_IS_CALL   = 2'd3
  } predecode_t;

  typedef struct packed {
    addr_t      pc;
    word_t      instr;
    predecode_t pd;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between icache and decode: splits 8-byte responses into PC-tagged entries, presents two per cycle.
// Outputs appear one edge after the push; in_ready comes from registered occupancy only, so same-cycle pops never raise it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [63:0]      in_data,
  input  logic [3:0]       in_predecode,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [63:0]      out_pc,
  output logic [63:0]      out_instr,
  output logic [3:0]       out_predecode,
  input  logic [1:0]       out_accept,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_aligned;
  logic             w_has1;
  logic             w_has2;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_n;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  fq_entry_t        w_wr0;
  fq_entry_t        w_wr1;

  assign in_ready  = (r_count <= CNT_W'(DEPTH - 2));
  assign w_push    = in_valid & in_ready;
  assign w_aligned = ~in_pc[2];
  assign w_has1    = (r_count != '0);
  assign w_has2    = (r_count >= CNT_W'(2));
  assign w_push_n  = w_push ? (w_aligned ? 2'd2 : 2'd1) : 2'd0;
  assign w_head1   = r_head + PTR_W'(1);
  assign w_tail1   = r_tail + PTR_W'(1);

  // 2'b10 is not a legal accept pattern and pops nothing
  always_comb begin
    w_pop_n = 2'd0;
    case (out_accept)
      2'b01:   w_pop_n = {1'b0, w_has1};
      2'b11:   w_pop_n = w_has2 ? 2'd2 : {1'b0, w_has1};
      default: w_pop_n = 2'd0;
    endcase
  end

  always_comb begin
    w_wr1.pc    = {in_pc[31:3], 3'b100};
    w_wr1.instr = in_data[63:32];
    w_wr1.pd    = predecode_t'(in_predecode[3:2]);
    if (w_aligned) begin
      w_wr0.pc    = {in_pc[31:3], 3'b000};
      w_wr0.instr = in_data[31:0];
      w_wr0.pd    = predecode_t'(in_predecode[1:0]);
    end else begin
      w_wr0 = w_wr1;
    end
  end

  // Storage is not reset; out_valid qualifies every read
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_tail] <= w_wr0;
      if (w_aligned) begin
        r_mem[w_tail1] <= w_wr1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
    end
  end

  assign count         = r_count;
  assign out_valid     = {w_has2, w_has1};
  assign out_pc        = {r_mem[w_head1].pc, r_mem[r_head].pc};
  assign out_instr     = {r_mem[w_head1].instr, r_mem[r_head].instr};
  assign out_predecode = {r_mem[w_head1].pd, r_mem[r_head].pd};

endmodule
